// File: rtl/md_sequencer.sv
// HI/LO owner and multi-cycle MULT/DIV controller; Busy for MULT_CYCLES/DIV_CYCLES, HI/LO commit as Busy falls.
// No backpressure: Starts arriving while Busy, cancelled, or with an undefined Op are dropped.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cancel,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, accept;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quot, rem;

  // Signed product via sign-extended operands: the low 64 bits are exact.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without a trap.
  assign div_signed = (Op == 3'b010);
  assign a_mag  = (div_signed && A[31]) ? -A : A;
  assign b_mag  = (div_signed && B[31]) ? -B : B;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;
  assign quot   = (div_signed && (A[31] ^ B[31])) ? -uq : uq;
  assign rem    = (div_signed && A[31]) ? -ur : ur;

  assign accept = Start && !Cancel && (state_q == S_IDLE) && (Op <= 3'b101);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (Op)
            3'b000, 3'b001: begin
              state_d   = S_MULT;
              cnt_d     = MULT_LOAD;
              busy_d    = 1'b1;
              pend_wr_d = 1'b1;
              pend_hi_d = (Op == 3'b000) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (Op == 3'b000) ? prod_s[31:0]  : prod_u[31:0];
            end
            3'b010, 3'b011: begin
              state_d   = S_DIV;
              cnt_d     = DIV_LOAD;
              busy_d    = 1'b1;
              pend_wr_d = (B != 32'd0);
              pend_hi_d = rem;
              pend_lo_d = quot;
            end
            3'b100:  hi_d = A;
            3'b101:  lo_d = A;
            default: ;
          endcase
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule
